// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the digit-serial add/sub unit.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_unit_if.sv
// Operand/result handshake bundle between the operand source, the add/sub unit
// and the result consumer.
interface serial_add_sub_unit_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero, negative
  );

endinterface

// File: rtl/serial_add_sub_unit_digit_add_cell.sv
// One DIGIT-bit slice of a ripple adder; the serial unit reuses it every cycle.
module digit_add_cell #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign sum  = full[DIGIT-1:0];
  assign cout = full[DIGIT];
  // The top sum bit is x ^ y ^ carry-in, so the carry into it falls back out.
  assign c_msb_in = x[DIGIT-1] ^ y[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/serial_add_sub_unit.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with valid/ready on both sides and registered result plus C/V/Z/N flags.
module serial_add_sub_unit
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst,
  serial_add_sub_unit_if.slave bus
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  generate
    if ((WIDTH % DIGIT) != 0 || DIGIT > WIDTH) begin : g_bad_params
      $error("serial_add_sub_unit: WIDTH must be a multiple of DIGIT and DIGIT <= WIDTH");
    end
  endgenerate

  state_t state, state_next;

  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       res_sh;
  logic                   mode_q;
  logic                   carry_q;
  logic [CNT_W-1:0]       digit_cnt;
  logic                   last_digit;

  logic [DIGIT-1:0]       x;
  logic [DIGIT-1:0]       y;
  logic [DIGIT-1:0]       sum;
  logic                   cout;
  logic                   c_msb_in;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  // Subtraction is A + ~B + 1: invert B per digit, the +1 is the seeded carry.
  assign x = a_sh[DIGIT-1:0];
  assign y = b_sh[DIGIT-1:0] ^ {DIGIT{mode_q == MODE_SUB}};

  digit_add_cell #(
    .DIGIT(DIGIT)
  ) u_cell (
    .x        (x),
    .y        (y),
    .cin      (carry_q),
    .sum      (sum),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // New digits enter at the MSB end so the word is LSB-aligned after the last one.
  assign res_cat    = {sum, res_sh};
  assign res_next   = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (digit_cnt == CNT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Visible result and flags only move on the final digit and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh          <= '0;
      b_sh          <= '0;
      res_sh        <= '0;
      mode_q        <= MODE_ADD;
      carry_q       <= 1'b0;
      digit_cnt     <= '0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.negative  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh      <= bus.a;
            b_sh      <= bus.b;
            mode_q    <= bus.mode;
            carry_q   <= (bus.mode == MODE_SUB);
            digit_cnt <= '0;
            res_sh    <= '0;
          end
        end
        BUSY: begin
          a_sh      <= a_sh >> DIGIT;
          b_sh      <= b_sh >> DIGIT;
          res_sh    <= res_next;
          carry_q   <= cout;
          digit_cnt <= digit_cnt + CNT_W'(1);
          if (last_digit) begin
            bus.result    <= res_next;
            bus.carry_out <= cout;
            bus.overflow  <= cout ^ c_msb_in;
            bus.zero      <= (res_next == '0);
            bus.negative  <= res_next[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed and randomised checks of serial_add_sub_unit at four WIDTH/DIGIT points,
// against a signed-arithmetic reference model.
module tb_serial_add_sub_unit;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: 8/2, 1: 16/4, 2: 8/8, 3: 8/1
  logic        t_valid [4];
  logic [15:0] t_a     [4];
  logic [15:0] t_b     [4];
  logic        t_mode  [4];
  logic        t_oready[4];

  logic        d_iready[4];
  logic        d_ovalid[4];
  logic [15:0] d_res   [4];
  logic        d_c     [4];
  logic        d_v     [4];
  logic        d_z     [4];
  logic        d_n     [4];

  serial_add_sub_unit_if #(.WIDTH(8))  bus0 ();
  serial_add_sub_unit_if #(.WIDTH(16)) bus1 ();
  serial_add_sub_unit_if #(.WIDTH(8))  bus2 ();
  serial_add_sub_unit_if #(.WIDTH(8))  bus3 ();

  serial_add_sub_unit #(.WIDTH(8),  .DIGIT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  serial_add_sub_unit #(.WIDTH(16), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_add_sub_unit #(.WIDTH(8),  .DIGIT(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  serial_add_sub_unit #(.WIDTH(8),  .DIGIT(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus0.in_valid = t_valid[0];  assign bus0.a = t_a[0][7:0];   assign bus0.b = t_b[0][7:0];
  assign bus0.mode = t_mode[0];       assign bus0.out_ready = t_oready[0];
  assign d_iready[0] = bus0.in_ready; assign d_ovalid[0] = bus0.out_valid; assign d_res[0] = {8'h00, bus0.result};
  assign d_c[0] = bus0.carry_out;     assign d_v[0] = bus0.overflow;  assign d_z[0] = bus0.zero; assign d_n[0] = bus0.negative;

  assign bus1.in_valid = t_valid[1];  assign bus1.a = t_a[1];        assign bus1.b = t_b[1];
  assign bus1.mode = t_mode[1];       assign bus1.out_ready = t_oready[1];
  assign d_iready[1] = bus1.in_ready; assign d_ovalid[1] = bus1.out_valid; assign d_res[1] = bus1.result;
  assign d_c[1] = bus1.carry_out;     assign d_v[1] = bus1.overflow;  assign d_z[1] = bus1.zero; assign d_n[1] = bus1.negative;

  assign bus2.in_valid = t_valid[2];  assign bus2.a = t_a[2][7:0];   assign bus2.b = t_b[2][7:0];
  assign bus2.mode = t_mode[2];       assign bus2.out_ready = t_oready[2];
  assign d_iready[2] = bus2.in_ready; assign d_ovalid[2] = bus2.out_valid; assign d_res[2] = {8'h00, bus2.result};
  assign d_c[2] = bus2.carry_out;     assign d_v[2] = bus2.overflow;  assign d_z[2] = bus2.zero; assign d_n[2] = bus2.negative;

  assign bus3.in_valid = t_valid[3];  assign bus3.a = t_a[3][7:0];   assign bus3.b = t_b[3][7:0];
  assign bus3.mode = t_mode[3];       assign bus3.out_ready = t_oready[3];
  assign d_iready[3] = bus3.in_ready; assign d_ovalid[3] = bus3.out_valid; assign d_res[3] = {8'h00, bus3.result};
  assign d_c[3] = bus3.carry_out;     assign d_v[3] = bus3.overflow;  assign d_z[3] = bus3.zero; assign d_n[3] = bus3.negative;

  function automatic int wid(input int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic int ndig(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: true signed sum/difference, then wrap and derive flags from it.
  function automatic exp_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic mode);
    exp_t   r;
    longint one  = 1;
    longint span = one << w;
    longint half = one << (w - 1);
    longint ua   = longint'(a) & (span - 1);
    longint ub   = longint'(b) & (span - 1);
    longint sa   = (ua >= half) ? ua - span : ua;
    longint sb   = (ub >= half) ? ub - span : ub;
    longint tr   = mode ? (sa - sb) : (sa + sb);
    longint wr   = tr & (span - 1);
    r.res = 16'(wr);
    r.v   = (tr > half - 1) || (tr < -half);
    r.c   = mode ? (ua >= ub) : ((ua + ub) >= span);
    r.z   = (wr == 0);
    r.n   = (wr >= half);
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_lit(input string tag, input exp_t got, input logic [15:0] r,
                           input logic c, input logic v, input logic z, input logic n);
    check_output({tag, ".result"},   32'(got.res), 32'(r));
    check_output({tag, ".carry"},    32'(got.c),   32'(c));
    check_output({tag, ".overflow"}, 32'(got.v),   32'(v));
    check_output({tag, ".zero"},     32'(got.z),   32'(z));
    check_output({tag, ".negative"}, 32'(got.n),   32'(n));
  endtask

  // Model state: phase 0 idle, 1 busy (cycles left in m_cnt), 2 done.
  int   m_phase[4];
  int   m_cnt  [4];
  exp_t m_pend [4];
  exp_t m_out  [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_phase[i] <= 0;
        m_cnt[i]   <= 0;
        m_out[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (m_phase[i])
          0: if (t_valid[i]) begin
            m_pend[i]  <= ref_op(wid(i), t_a[i], t_b[i], t_mode[i]);
            m_cnt[i]   <= ndig(i);
            m_phase[i] <= 1;
          end
          1: if (m_cnt[i] == 1) begin
            m_phase[i] <= 2;
            m_out[i]   <= m_pend[i];
          end else begin
            m_cnt[i] <= m_cnt[i] - 1;
          end
          default: if (t_oready[i]) m_phase[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        check_output($sformatf("in_ready[%0d]", i),  32'(d_iready[i]), 32'(m_phase[i] == 0));
        check_output($sformatf("out_valid[%0d]", i), 32'(d_ovalid[i]), 32'(m_phase[i] == 2));
        check_output($sformatf("result[%0d]", i),    32'(d_res[i]),    32'(m_out[i].res));
        check_output($sformatf("carry[%0d]", i),     32'(d_c[i]),      32'(m_out[i].c));
        check_output($sformatf("overflow[%0d]", i),  32'(d_v[i]),      32'(m_out[i].v));
        check_output($sformatf("zero[%0d]", i),      32'(d_z[i]),      32'(m_out[i].z));
        check_output($sformatf("negative[%0d]", i),  32'(d_n[i]),      32'(m_out[i].n));
      end
    end
  end

  // Present one operation, measure accept-to-out_valid latency, then consume it.
  task automatic apply_stimulus(input int i, input logic [15:0] a, input logic [15:0] b,
                                input logic mode, output exp_t got, output int lat);
    int guard = 0;
    @(negedge clk);
    t_a[i] = a; t_b[i] = b; t_mode[i] = mode; t_valid[i] = 1'b1;
    while (!d_iready[i] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_in_time", 32'(guard < 100), 32'd1);
    @(negedge clk);
    t_valid[i] = 1'b0;
    lat = 0;
    while (!d_ovalid[i] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_output("result_in_time", 32'(lat < 100), 32'd1);
    got = '{d_res[i], d_c[i], d_v[i], d_z[i], d_n[i]};
    t_oready[i] = 1'b1;
    @(negedge clk);
    t_oready[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t got;
    int   lat;
    int   guard;
    for (int i = 0; i < 4; i++) begin
      t_valid[i] = 1'b0; t_a[i] = '0; t_b[i] = '0; t_mode[i] = 1'b0; t_oready[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check_lit("reset", '{d_res[0], d_c[0], d_v[0], d_z[0], d_n[0]}, 16'h0000, 0, 0, 0, 0);
    check_output("reset.in_ready",  32'(d_iready[0]), 32'd1);
    check_output("reset.out_valid", 32'(d_ovalid[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Plain adds and the latency of the 8/2 configuration
    apply_stimulus(0, 16'h03, 16'h01, 1'b0, got, lat);
    check_lit("add_03_01", got, 16'h04, 0, 0, 0, 0);
    check_output("add_03_01.latency", 32'(lat), 32'd4);
    apply_stimulus(0, 16'hFF, 16'h01, 1'b0, got, lat);
    check_lit("add_ff_01", got, 16'h00, 1, 0, 1, 0);

    // Signed overflow both directions
    apply_stimulus(0, 16'h7F, 16'h01, 1'b0, got, lat);
    check_lit("add_7f_01", got, 16'h80, 0, 1, 0, 1);
    apply_stimulus(0, 16'h80, 16'h01, 1'b1, got, lat);
    check_lit("sub_80_01", got, 16'h7F, 1, 1, 0, 0);

    // Borrow / no borrow
    apply_stimulus(0, 16'h05, 16'h03, 1'b1, got, lat);
    check_lit("sub_05_03", got, 16'h02, 1, 0, 0, 0);
    apply_stimulus(0, 16'h00, 16'h01, 1'b1, got, lat);
    check_lit("sub_00_01", got, 16'hFF, 0, 0, 0, 1);

    // Backpressure and in_valid ignored while busy
    @(negedge clk);
    t_a[0] = 16'h03; t_b[0] = 16'h01; t_mode[0] = 1'b0; t_valid[0] = 1'b1;
    @(negedge clk);
    t_a[0] = 16'h11; t_b[0] = 16'h00;
    check_output("busy.in_ready", 32'(d_iready[0]), 32'd0);
    @(negedge clk);
    t_valid[0] = 1'b0;
    guard = 0;
    while (!d_ovalid[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("busy.result_in_time", 32'(guard < 100), 32'd1);
    t_a[0] = 16'h20; t_b[0] = 16'h02; t_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_lit("held", '{d_res[0], d_c[0], d_v[0], d_z[0], d_n[0]}, 16'h04, 0, 0, 0, 0);
      check_output("held.out_valid", 32'(d_ovalid[0]), 32'd1);
      check_output("held.in_ready",  32'(d_iready[0]), 32'd0);
      @(negedge clk);
    end
    t_oready[0] = 1'b1;
    @(negedge clk);
    t_oready[0] = 1'b0;
    @(negedge clk);
    t_valid[0] = 1'b0;
    guard = 0;
    while (!d_ovalid[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_lit("after_idle", '{d_res[0], d_c[0], d_v[0], d_z[0], d_n[0]}, 16'h22, 0, 0, 0, 0);
    t_oready[0] = 1'b1;
    @(negedge clk);
    t_oready[0] = 1'b0;

    // Asynchronous reset partway through a BUSY operation
    @(negedge clk);
    t_a[0] = 16'h05; t_b[0] = 16'h05; t_mode[0] = 1'b0; t_valid[0] = 1'b1;
    @(negedge clk);
    t_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_lit("mid_reset", '{d_res[0], d_c[0], d_v[0], d_z[0], d_n[0]}, 16'h00, 0, 0, 0, 0);
    check_output("mid_reset.in_ready",  32'(d_iready[0]), 32'd1);
    check_output("mid_reset.out_valid", 32'(d_ovalid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 16'h10, 16'h20, 1'b0, got, lat);
    check_lit("add_10_20", got, 16'h30, 0, 0, 0, 0);
    check_output("add_10_20.latency", 32'(lat), 32'd4);

    // Parameter sweep: wrap boundaries then random operands
    for (int i = 0; i < 4; i++) begin
      logic [15:0] mask;
      logic [15:0] msb;
      mask = (wid(i) == 16) ? 16'hFFFF : 16'h00FF;
      msb  = (wid(i) == 16) ? 16'h8000 : 16'h0080;
      for (int j = 0; j < 10; j++) begin
        logic [15:0] a;
        logic [15:0] b;
        logic        mode;
        exp_t        e;
        case (j)
          0: begin a = mask;        b = 16'h1; mode = 1'b0; end
          1: begin a = msb;         b = 16'h1; mode = 1'b1; end
          2: begin a = msb - 16'h1; b = 16'h1; mode = 1'b0; end
          3: begin a = 16'h0;       b = 16'h0; mode = 1'b1; end
          default: begin
            a    = 16'($urandom) & mask;
            b    = 16'($urandom) & mask;
            mode = 1'($urandom_range(0, 1));
          end
        endcase
        e = ref_op(wid(i), a, b, mode);
        apply_stimulus(i, a, b, mode, got, lat);
        check_lit($sformatf("sweep%0d_%0d", i, j), got, e.res, e.c, e.v, e.z, e.n);
        check_output($sformatf("sweep%0d_%0d.latency", i, j), 32'(lat), 32'(ndig(i)));
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
